serial_magnitude_comp: RTL and testbench
========================================

// Module: serial_magnitude_comp
// PURPOSE
//  Parametrised, sequential successor to the fixed 4-bit comparator.
//  Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and terminates early on the first unequal digit.
//  Supports an unsigned mode and a two's-complement signed mode.
//  Used where a wide combinational comparator would break timing: a start/busy/done handshake feeds the control FSMs.
// PARAMETERS
//  WIDTH  8  operand width in bits; >= 1
//  DIGIT  2  bits compared per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0 (sim-time $error otherwise)
//  Derived: NDIG = WIDTH/DIGIT digits; digit 0 is the most significant
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request a compare; sampled only when busy==0
//  signed_en  in   1      1 = two's-complement compare, 0 = unsigned; captured with start
//  a          in   WIDTH  operand A; captured with start
//  b          in   WIDTH  operand B; captured with start
//  busy       out  1      compare in progress
//  done       out  1      one-cycle pulse; lt/eq/gt updated in the same cycle
//  lt         out  1      A < B  (result of the last completed compare)
//  eq         out  1      A == B
//  gt         out  1      A > B
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE; busy, done, lt, eq and gt all 0; internal operand registers cleared.
//  - Reset has priority over every other input, including mid-compare. An aborted compare produces no done, and the outputs go to 0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN
//    RUN --(mismatch at digit k) or (k==NDIG-1)--> DONE
//    DONE --start--> RUN, otherwise DONE --> IDLE
//  - Capture: on a start accepted at edge T:
//    a_r <= a, b_r <= b, digit index k <= 0, busy=1 from T.
//    If signed_en=1, the MSB of both a_r and b_r is inverted at capture (offset-binary trick), so the digit compare stays unsigned throughout.
//  - RUN: each cycle compares digit k of a_r against digit k of b_r (unsigned, DIGIT bits).
//    * Unequal: register lt/gt accordingly, eq=0, done=1 and busy=0 at the next edge.
//    * Equal and k<NDIG-1: k <= k+1.
//    * Equal and k==NDIG-1: eq=1, lt=gt=0, done=1.
//  - Latency: done is high in cycle T+1+k, where k is the first unequal digit, or NDIG-1 if A==B.
//    Minimum is 1 cycle; maximum is NDIG cycles after the accepting edge.
//  - done is high for exactly one cycle. lt/eq/gt hold their value until the next done or reset.
//    They are never updated mid-compare and are one-hot after the first completed compare.
//  - busy=0 during the DONE cycle, so a start in that cycle is accepted: back-to-back compares with no idle gap.
//  - start while busy==1 is ignored with no side effects.
//    Changes to a, b or signed_en while busy do not affect the running compare.
//  - No combinational path from inputs to outputs; all outputs are registered.
// TESTING  (WIDTH=8, DIGIT=2, NDIG=4 unless stated; T = accepting edge)
//  1. Hold rst=1 for 2 cycles with random inputs -> busy=done=lt=eq=gt=0. A start during reset is ignored.
//  2. a=8'hA5, b=8'hA5, signed_en=0 -> done only in cycle T+4 with eq=1, lt=gt=0; busy high for cycles T+1..T+3.
//  3. a=8'h80, b=8'h7F, signed_en=0 -> done at T+1, gt=1. Same operands with signed_en=1 -> done at T+1, lt=1.
//  4. a=8'h12, b=8'h13 -> first mismatch at digit 3, done at T+4, lt=1.
//     Extra start pulses and a/b changes during busy are ignored; a start in the done cycle launches the next compare immediately.
//  5. Start a=8'h00, b=8'hFF, signed_en=1, then assert rst in cycle T+1 -> no done pulse, outputs 0.
//     A fresh start after reset completes correctly (eq for a=b=8'h3C).
//  6. Exhaustive run with WIDTH=4, DIGIT=1: all 256 (a,b) pairs in both modes, checked against $signed/$unsigned compares.
//     Each result must be one-hot, and each latency must equal the first-mismatch index + 1.

Source files
------------

// File: rtl/serial_magnitude_comp.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, early exit on the first unequal digit.
// Signed mode flips both MSBs at capture so the digit datapath stays a plain unsigned compare.
module serial_magnitude_comp #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_magnitude_comp: DIGIT must be in 1..WIDTH and divide WIDTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [KW-1:0]    r_k;
   logic             r_busy;
   logic             r_done;
   logic             r_lt;
   logic             r_eq;
   logic             r_gt;

   logic [WIDTH-1:0] w_flip;
   logic [DIGIT-1:0] w_da;
   logic [DIGIT-1:0] w_db;

   assign w_flip = signed_en ? (WIDTH'(1) << (WIDTH - 1)) : '0;
   // Operands shift left as digits are consumed, so the current digit is always the top slice.
   assign w_da   = r_a[WIDTH-1 -: DIGIT];
   assign w_db   = r_b[WIDTH-1 -: DIGIT];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lt    <= 1'b0;
         r_eq    <= 1'b0;
         r_gt    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_da != w_db) begin
                  r_lt    <= (w_da < w_db);
                  r_eq    <= 1'b0;
                  r_gt    <= (w_da > w_db);
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else if (r_k == K_LAST) begin
                  r_lt    <= 1'b0;
                  r_eq    <= 1'b1;
                  r_gt    <= 1'b0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_k <= r_k + KW'(1);
                  r_a <= r_a << DIGIT;
                  r_b <= r_b << DIGIT;
               end
            end
            default: begin
               // IDLE and DONE both accept a start; DONE falls back to IDLE otherwise.
               if (start) begin
                  r_a     <= a ^ w_flip;
                  r_b     <= b ^ w_flip;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign lt   = r_lt;
   assign eq   = r_eq;
   assign gt   = r_gt;

endmodule

// File: tb/tb_serial_magnitude_comp.sv
// Bench for serial_magnitude_comp: an 8-bit/2-bit instance and a 4-bit/1-bit instance
// checked against an arithmetic reference for result and first-mismatch latency.
module tb_serial_magnitude_comp;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, se8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, lt8, eq8, gt8;
   logic       start4 = 1'b0, se4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, lt4, eq4, gt4;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   serial_magnitude_comp #(.WIDTH(8), .DIGIT(2)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_en(se8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8));

   serial_magnitude_comp #(.WIDTH(4), .DIGIT(1)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_en(se4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4));

   function automatic logic [2:0] cur_res(input bit s);
      return s ? {lt4, eq4, gt4} : {lt8, eq8, gt8};
   endfunction

   function automatic logic cur_busy(input bit s);
      return s ? busy4 : busy8;
   endfunction

   function automatic logic cur_done(input bit s);
      return s ? done4 : done8;
   endfunction

   // Reference: result from integer compare, latency from first differing digit of a^b.
   function automatic void model(input bit s, input logic [7:0] ia, input logic [7:0] ib,
                                 input logic sg, output logic [2:0] res, output int lat);
      int  w, d, va, vb, x;
      bit  found;
      w = s ? 4 : 8;
      d = s ? 1 : 2;
      if (sg) begin
         va = s ? int'($signed(ia[3:0])) : int'($signed(ia));
         vb = s ? int'($signed(ib[3:0])) : int'($signed(ib));
      end else begin
         va = s ? int'(ia[3:0]) : int'(ia);
         vb = s ? int'(ib[3:0]) : int'(ib);
      end
      res = (va < vb) ? 3'b100 : ((va == vb) ? 3'b010 : 3'b001);
      x = int'(ia ^ ib) & ((1 << w) - 1);
      lat = 4;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!found && (((x >> (w - (i + 1) * d)) & ((1 << d) - 1)) != 0)) begin
            lat = i + 1;
            found = 1'b1;
         end
      end
   endfunction

   // Entered #1 after an edge with the selected DUT not busy; launches one compare.
   task automatic do_cmp(input bit s, input logic [7:0] ia, input logic [7:0] ib, input logic sg,
                         input bit disturb, input bit chain, input string nm);
      logic [2:0] exp_r, prev;
      int         exp_lat, n;
      bit         got;
      model(s, ia, ib, sg, exp_r, exp_lat);
      prev = cur_res(s);
      if (s) begin a4 = ia[3:0]; b4 = ib[3:0]; se4 = sg; start4 = 1'b1; end
      else   begin a8 = ia;      b8 = ib;      se8 = sg; start8 = 1'b1; end
      @(posedge clk); #1;
      start4 = 1'b0; start8 = 1'b0;
      checks++;
      if (cur_busy(s) !== 1'b1 || cur_done(s) !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", nm, cur_busy(s), cur_done(s));
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 12) begin
         if (disturb) begin
            if (s) begin a4 = 4'($urandom); b4 = 4'($urandom); se4 = 1'($urandom); start4 = 1'($urandom); end
            else   begin a8 = 8'($urandom); b8 = 8'($urandom); se8 = 1'($urandom); start8 = 1'($urandom); end
         end
         @(posedge clk); #1;
         n++;
         if (cur_done(s) === 1'b1) begin
            got = 1'b1;
         end else begin
            checks++;
            if (cur_busy(s) !== 1'b1 || cur_res(s) !== prev) begin
               errors++;
               $display("FAIL %s mid cycle %0d: busy=%b res=%b, required busy=1 res=%b", nm, n, cur_busy(s), cur_res(s), prev);
            end
         end
      end
      start4 = 1'b0; start8 = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles, required latency %0d", nm, n, exp_lat);
      end else begin
         if (n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", nm, n, exp_lat);
         end
         checks++;
         if (cur_res(s) !== exp_r || cur_busy(s) !== 1'b0) begin
            errors++;
            $display("FAIL %s result: ltqgt=%b busy=%b, required ltqgt=%b busy=0", nm, cur_res(s), cur_busy(s), exp_r);
         end
      end
      if (!chain) begin
         @(posedge clk); #1;
         checks++;
         if (cur_done(s) !== 1'b0 || cur_busy(s) !== 1'b0 || cur_res(s) !== exp_r) begin
            errors++;
            $display("FAIL %s after: done=%b busy=%b res=%b, required done=0 busy=0 res=%b", nm, cur_done(s), cur_busy(s), cur_res(s), exp_r);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); se8 = 1'($urandom); start8 = 1'b1;
         a4 = 4'($urandom); b4 = 4'($urandom); se4 = 1'($urandom); start4 = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if ({busy8, done8, lt8, eq8, gt8} !== 5'b0) begin
         errors++;
         $display("FAIL reset8: busy,done,lt,eq,gt=%b, required 00000", {busy8, done8, lt8, eq8, gt8});
      end
      checks++;
      if ({busy4, done4, lt4, eq4, gt4} !== 5'b0) begin
         errors++;
         $display("FAIL reset4: busy,done,lt,eq,gt=%b, required 00000", {busy4, done4, lt4, eq4, gt4});
      end
      rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8, busy4, done4} !== 4'b0) begin
         errors++;
         $display("FAIL reset_release: busy8,done8,busy4,done4=%b, required 0000", {busy8, done8, busy4, done4});
      end
   endtask

   task automatic test_directed();
      do_cmp(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, "eq_A5");
      do_cmp(1'b0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, "unsigned_80_7F");
      do_cmp(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, "signed_80_7F");
      do_cmp(1'b0, 8'h12, 8'h13, 1'b0, 1'b0, 1'b0, "lt_12_13");
   endtask

   task automatic test_busy_ignore();
      do_cmp(1'b0, 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, "ignore_busy");
      do_cmp(1'b0, 8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, "ignore_busy_signed");
   endtask

   task automatic test_back_to_back();
      do_cmp(1'b0, 8'h12, 8'h13, 1'b0, 1'b1, 1'b1, "b2b_0");
      do_cmp(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, "b2b_1");
      do_cmp(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, "b2b_2");
   endtask

   task automatic test_abort();
      a8 = 8'h00; b8 = 8'hFF; se8 = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8, lt8, eq8, gt8} !== 5'b0) begin
         errors++;
         $display("FAIL abort: busy,done,lt,eq,gt=%b, required 00000", {busy8, done8, lt8, eq8, gt8});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8} !== 2'b0) begin
         errors++;
         $display("FAIL abort_after: busy,done=%b, required 00", {busy8, done8});
      end
      do_cmp(1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, "after_abort_eq");
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         do_cmp(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                (i != 149) && 1'($urandom), "rand8");
      end
      // Near-equal operands exercise the late-digit exits.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] x;
         x = 8'($urandom);
         do_cmp(1'b0, x, x ^ 8'(1 << $urandom_range(0, 7)), 1'($urandom), 1'b0, 1'b0, "near8");
      end
   endtask

   task automatic test_exhaustive4();
      for (int sg = 0; sg < 2; sg++)
         for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
               do_cmp(1'b1, 8'(ia), 8'(ib), 1'(sg), 1'b0, ib[0], "exh4");
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_back_to_back();
      test_abort();
      test_random();
      test_exhaustive4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
